// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_to_bin_if : request/result bundle for the BCD-to-binary converter       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface bcd_to_bin_if #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  bin,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output bin,
    output busy,
    output done,
    output err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bcd_to_bin : sequential reverse double-dabble, one bit per clock           |
// | Optional digit check enabled by macro BCD_CHECK_EN.   Rev 1.0              |
// +----------------------------------------------------------------------------+
module bcd_to_bin #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  wire logic    clk,
  input  wire logic    rst,
  bcd_to_bin_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_shift_w;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   binw_q;
  logic [BIN_W-1:0]   binw_d;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               bad_digit_w;
  logic               last_shift_w;

  assign bcd_shift_w  = bcd_q >> 1;
  assign binw_d       = {bcd_q[0], binw_q[BIN_W-1:1]};
  assign last_shift_w = (cnt_q == CNT_W'(BIN_W - 1));

  // After each right shift a digit >= 8 holds a borrowed 10 rather than 16; take back 3.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit_adj
      assign bcd_d[4*i +: 4] = bcd_shift_w[4*i + 3] ? (bcd_shift_w[4*i +: 4] - 4'd3)
                                                    : bcd_shift_w[4*i +: 4];
    end
  endgenerate

`ifdef BCD_CHECK_EN
  logic [DIGITS-1:0] dig_bad_w;
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit_chk
      assign dig_bad_w[i] = (bus.bcd_in[4*i +: 4] > 4'd9);
    end
  endgenerate
  assign bad_digit_w = |dig_bad_w;
`else
  assign bad_digit_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      binw_q  <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bcd_q  <= bus.bcd_in;
            binw_q <= '0;
            cnt_q  <= '0;
            if (bad_digit_w) begin
              err_q   <= 1'b1;
              bin_q   <= '0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          bcd_q  <= bcd_d;
          binw_q <= binw_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_shift_w) begin
            bin_q   <= binw_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule
`default_nettype wire
